// File: rtl/rvx_apb_requester.sv
// APB initiator: converts a valid/ready request channel into APB SETUP/ACCESS transfers
// and returns read data, slave error and timeout status on a valid/ready response channel.
`timescale 1ns/1ps
module rvx_apb_requester #(
   parameter int unsigned BW_ADDR = 12,
   parameter int unsigned BW_DATA = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [BW_ADDR-1:0] req_addr,
   input  logic               req_write,
   input  logic [BW_DATA-1:0] req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [BW_DATA-1:0] resp_rdata,
   output logic               resp_error,
   output logic               resp_timeout,
   output logic [BW_ADDR-1:0] paddr,
   output logic               pwrite,
   output logic               psel,
   output logic               penable,
   output logic [BW_DATA-1:0] pwdata,
   input  logic [BW_DATA-1:0] prdata,
   input  logic               pready,
   input  logic               pslverr,
   output logic               busy
);

   localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          timeout_hit;

   always_comb begin
      state_nxt   = state;
      req_ready   = 1'b0;
      busy        = 1'b1;
      timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = SETUP;
         end
         SETUP:  state_nxt = ACCESS;
         ACCESS: if (pready || timeout_hit) state_nxt = RESP;
         RESP:   if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus strobes and resp_valid are flops fed from the next state, so they carry
   // no combinational path from req_* or pready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         psel         <= 1'b0;
         penable      <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_error   <= 1'b0;
         resp_timeout <= 1'b0;
         paddr        <= '0;
         pwrite       <= 1'b0;
         pwdata       <= '0;
         cnt          <= '0;
      end else begin
         state      <= state_nxt;
         psel       <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         penable    <= (state_nxt == ACCESS);
         resp_valid <= (state_nxt == RESP);
         unique case (state)
            IDLE: if (req_valid) begin
               paddr  <= req_addr;
               pwrite <= req_write;
               pwdata <= req_wdata;
            end
            SETUP: cnt <= '0;
            ACCESS: begin
               if (pready) begin
                  resp_rdata   <= pwrite ? '0 : prdata;
                  resp_error   <= pslverr;
                  resp_timeout <= 1'b0;
               end else if (timeout_hit) begin
                  resp_rdata   <= '0;
                  resp_error   <= 1'b1;
                  resp_timeout <= 1'b1;
               end else if (cnt != '1) begin
                  // saturates: with timeout disabled the counter must not wrap
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
